// File: rtl/scanline_buf_ctrl.sv
// Ping-pong scanline buffer between PPU pixel output and VGA scanout.
// PPU fills one bank while VGA shows the other; each line is repeated REPEAT rows.
module scanline_buf_ctrl #(
  parameter int IDX_W = 8,
  parameter int PIX_W = 6,
  parameter int REPEAT = 2,
  parameter logic [PIX_W-1:0] BLANK_IDX = 6'h0F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             ppu_pix_valid,
  input  logic [IDX_W-1:0] ppu_pix_x,
  input  logic [PIX_W-1:0] ppu_pix_data,
  input  logic             ppu_line_done,
  input  logic             vga_line_start,
  input  logic             vga_frame_start,
  input  logic [IDX_W-1:0] vga_buf_idx,
  output logic [PIX_W-1:0] vga_buf_out,
  output logic             wr_bank,
  output logic             rd_bank,
  output logic             rd_active,
  output logic             overrun,
  output logic             underrun,
  input  logic             err_clr
);

  localparam int LEN = 2 ** IDX_W;
  localparam logic [1:0] REP = REPEAT[1:0];

  localparam logic [0:0] W_FILL = 1'b0;
  localparam logic [0:0] W_WAIT = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_SHOW = 1'b1;

  logic [PIX_W-1:0] mem [0:2*LEN-1];

  logic [0:0] w_state;
  logic [0:0] r_state;
  logic [1:0] bank_full;
  logic [1:0] rep_cnt;
  logic [1:0] full_set;
  logic [1:0] full_clr;
  logic       ovr_set;
  logic       und_set;

  always_ff @(posedge clk) begin
    if (!rst && clk_en && w_state == W_FILL && ppu_pix_valid)
      mem[{wr_bank, ppu_pix_x}] <= ppu_pix_data;
  end

  // Bank ownership changes from both sides merge here; a set wins over a clear.
  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    ovr_set  = 1'b0;
    und_set  = 1'b0;
    if (w_state == W_FILL && ppu_line_done)
      full_set[wr_bank] = 1'b1;
    if (w_state == W_WAIT && (ppu_pix_valid || ppu_line_done))
      ovr_set = 1'b1;
    if (r_state == R_SHOW) begin
      if (vga_frame_start)
        full_clr[rd_bank] = 1'b1;
      else if (vga_line_start && rep_cnt == REP) begin
        if (bank_full[~rd_bank])
          full_clr[rd_bank] = 1'b1;
        else
          und_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      rep_cnt   <= 2'd0;
      w_state   <= W_FILL;
      r_state   <= R_IDLE;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else if (clk_en) begin
      bank_full <= (bank_full & ~full_clr) | full_set;
      overrun   <= ovr_set | (overrun & ~err_clr);
      underrun  <= und_set | (underrun & ~err_clr);

      case (w_state)
        W_FILL: begin
          if (ppu_line_done) begin
            if (!bank_full[~wr_bank])
              wr_bank <= ~wr_bank;
            else
              w_state <= W_WAIT;
          end
        end
        default: begin
          if (!bank_full[~wr_bank]) begin
            wr_bank <= ~wr_bank;
            w_state <= W_FILL;
          end
        end
      endcase

      // Frame start overrides a coincident line start.
      if (vga_frame_start) begin
        r_state <= R_IDLE;
        rep_cnt <= 2'd0;
      end else if (vga_line_start) begin
        case (r_state)
          R_IDLE: begin
            if (bank_full[~wr_bank]) begin
              rd_bank <= ~wr_bank;
              rep_cnt <= 2'd1;
              r_state <= R_SHOW;
            end else if (w_state == W_WAIT && bank_full[wr_bank]) begin
              rd_bank <= wr_bank;
              rep_cnt <= 2'd1;
              r_state <= R_SHOW;
            end
          end
          default: begin
            if (rep_cnt < REP)
              rep_cnt <= rep_cnt + 2'd1;
            else if (bank_full[~rd_bank]) begin
              rd_bank <= ~rd_bank;
              rep_cnt <= 2'd1;
            end
          end
        endcase
      end
    end
  end

  assign rd_active   = (r_state == R_SHOW);
  assign vga_buf_out = (r_state == R_SHOW) ? mem[{rd_bank, vga_buf_idx}] : BLANK_IDX;

endmodule
